// File: rtl/bootctrl_multi.sv
`default_nettype none
// ============================================================================
// Module  : bootctrl_multi
// Brief   : Multi-hart boot controller. Per-hart reset sequencing with
//           latched entry PC / DRAM base, per-hart watchdog, register window
//           on a simple regbus and a registered debug PC tap.
// Revision: 1.0 - initial release
// ============================================================================
module bootctrl_multi #(
  parameter int          NUM_HARTS  = 2,
  parameter logic [15:0] BASE_ADDR  = 16'h1000,
  parameter int          RST_CYCLES = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [15:0]               WRADDR,
  input  logic [3:0]                BYTEEN,
  input  logic                      WREN,
  input  logic [31:0]               WDATA,
  input  logic [15:0]               RDADDR,
  input  logic                      RDEN,
  output logic [31:0]               RDATA,
  input  logic [32*NUM_HARTS-1:0]   hart_last_pc,
  output logic [NUM_HARTS-1:0]      hart_rst,
  output logic [32*NUM_HARTS-1:0]   hart_entry_pc,
  output logic [32*NUM_HARTS-1:0]   hart_dram_base,
  output logic [31:0]               DEBUG
);

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_STARTING = 2'd1,
    ST_RUN      = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam logic [15:0] OFF_WDT   = 16'h0100;
  localparam logic [15:0] OFF_DBG   = 16'h0104;
  localparam logic [7:0]  CNT_INIT  = 8'(RST_CYCLES - 1);

  // Per-hart architectural state
  state_t                 state     [NUM_HARTS];
  logic [NUM_HARTS-1:0]   hold_reset;
  logic [31:0]            dram_base [NUM_HARTS];
  logic [31:0]            entry_pc  [NUM_HARTS];
  logic [31:0]            wdt_cnt   [NUM_HARTS];
  logic [31:0]            prev_pc   [NUM_HARTS];
  logic [7:0]             start_cnt [NUM_HARTS];

  // Global registers
  logic [31:0]            wdt_limit;
  logic [2:0]             debug_sel;

  // Window-relative offsets; addresses below the base wrap to large values
  // and therefore fall outside every decoded region.
  logic [15:0]            wr_off;
  logic [15:0]            rd_off;
  assign wr_off = WRADDR - BASE_ADDR;
  assign rd_off = RDADDR - BASE_ADDR;

  // Per-hart write strobes and FSM events
  logic [NUM_HARTS-1:0]   ctrl_wr;
  logic [NUM_HARTS-1:0]   dram_wr;
  logic [NUM_HARTS-1:0]   entry_wr;
  logic [NUM_HARTS-1:0]   start_p;
  logic [NUM_HARTS-1:0]   stop_p;
  logic [NUM_HARTS-1:0]   clr_p;
  logic [NUM_HARTS-1:0]   hold_next;
  logic [NUM_HARTS-1:0]   pc_chg;
  logic [NUM_HARTS-1:0]   wdt_trip;

  logic                   wdt_wr;
  logic                   sel_wr;
  logic [31:0]            rd_value;
  logic [31:0]            dbg_value;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Decode writes into per-hart strobes and derive FSM events for this cycle
  always_comb begin
    ctrl_wr   = '0;
    dram_wr   = '0;
    entry_wr  = '0;
    start_p   = '0;
    stop_p    = '0;
    clr_p     = '0;
    hold_next = '0;
    pc_chg    = '0;
    wdt_trip  = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (WREN && (wr_off[1:0] == 2'b00) && (wr_off[15:4] == 12'(h))) begin
        ctrl_wr[h]  = (wr_off[3:2] == 2'd1);
        dram_wr[h]  = (wr_off[3:2] == 2'd2);
        entry_wr[h] = (wr_off[3:2] == 2'd3);
      end
      start_p[h]   = ctrl_wr[h] & BYTEEN[0] & WDATA[1];
      stop_p[h]    = ctrl_wr[h] & BYTEEN[0] & WDATA[2];
      clr_p[h]     = ctrl_wr[h] & BYTEEN[0] & WDATA[3];
      // HOLD_RESET as it will be after this cycle's write
      hold_next[h] = (ctrl_wr[h] & BYTEEN[0]) ? WDATA[0] : hold_reset[h];
      pc_chg[h]    = (hart_last_pc[32*h +: 32] != prev_pc[h]);
      // Compare with >= so a limit lowered below a running count still trips
      wdt_trip[h]  = (wdt_limit != 32'd0) && (wdt_cnt[h] >= wdt_limit);
    end
  end

  assign wdt_wr = WREN && (wr_off == OFF_WDT);
  assign sel_wr = WREN && (wr_off == OFF_DBG) && BYTEEN[0];

  // Per-hart config registers, hart FSMs, watchdogs and latched boot outputs
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        state[h]     <= ST_HOLD;
        dram_base[h] <= '0;
        entry_pc[h]  <= '0;
        wdt_cnt[h]   <= '0;
        prev_pc[h]   <= '0;
        start_cnt[h] <= '0;
      end
      hold_reset     <= '1;
      hart_rst       <= '1;
      hart_entry_pc  <= '0;
      hart_dram_base <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        prev_pc[h]    <= hart_last_pc[32*h +: 32];
        hold_reset[h] <= hold_next[h];
        if (dram_wr[h])  dram_base[h] <= byte_merge(dram_base[h], WDATA, BYTEEN);
        if (entry_wr[h]) entry_pc[h]  <= byte_merge(entry_pc[h], WDATA, BYTEEN);

        // Watchdog: any PC movement restarts the count; RUN entry below overrides
        if (pc_chg[h]) begin
          wdt_cnt[h] <= '0;
        end else if ((state[h] == ST_RUN) && (wdt_cnt[h] != '1)) begin
          wdt_cnt[h] <= wdt_cnt[h] + 32'd1;
        end

        case (state[h])
          ST_HOLD: begin
            if (start_p[h] && !stop_p[h] && !hold_next[h]) begin
              state[h]                 <= ST_STARTING;
              start_cnt[h]             <= CNT_INIT;
              hart_entry_pc[32*h +: 32]  <= entry_pc[h];
              hart_dram_base[32*h +: 32] <= dram_base[h];
            end
          end
          ST_STARTING: begin
            if (stop_p[h] || hold_next[h]) begin
              state[h] <= ST_HOLD;
            end else if (start_cnt[h] == 8'd0) begin
              state[h]    <= ST_RUN;
              hart_rst[h] <= 1'b0;
              wdt_cnt[h]  <= '0;
            end else begin
              start_cnt[h] <= start_cnt[h] - 8'd1;
            end
          end
          ST_RUN: begin
            // STOP / HOLD_RESET take priority over a coincident watchdog trip
            if (stop_p[h] || hold_next[h]) begin
              state[h]    <= ST_HOLD;
              hart_rst[h] <= 1'b1;
            end else if (wdt_trip[h]) begin
              state[h]    <= ST_FAULT;
              hart_rst[h] <= 1'b1;
            end
          end
          ST_FAULT: begin
            if (clr_p[h]) state[h] <= ST_HOLD;
          end
          default: begin
            state[h]    <= ST_HOLD;
            hart_rst[h] <= 1'b1;
          end
        endcase
      end
    end
  end

  // Global registers: watchdog limit and debug hart selector
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wdt_limit <= '0;
      debug_sel <= '0;
    end else begin
      if (wdt_wr) wdt_limit <= byte_merge(wdt_limit, WDATA, BYTEEN);
      if (sel_wr) debug_sel <= WDATA[2:0];
    end
  end

  // Read mux over pre-write register contents; unmapped offsets give zero
  always_comb begin
    rd_value = '0;
    if (rd_off[1:0] == 2'b00) begin
      if (rd_off == OFF_WDT) rd_value = wdt_limit;
      if (rd_off == OFF_DBG) rd_value = {29'b0, debug_sel};
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (rd_off[15:4] == 12'(h)) begin
          case (rd_off[3:2])
            2'd0:    rd_value = {27'b0, state[h], (state[h] == ST_FAULT),
                                 hold_reset[h], (state[h] == ST_RUN)};
            2'd1:    rd_value = {31'b0, hold_reset[h]};
            2'd2:    rd_value = dram_base[h];
            default: rd_value = entry_pc[h];
          endcase
        end
      end
    end
  end

  // Read data register: captures on RDEN, otherwise holds
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      RDATA <= '0;
    end else if (RDEN) begin
      RDATA <= rd_value;
    end
  end

  // Select the debug hart's PC; selectors past the last hart give zero
  always_comb begin
    dbg_value = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (debug_sel == 3'(h)) dbg_value = hart_last_pc[32*h +: 32];
    end
  end

  // Registered debug PC output
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      DEBUG <= '0;
    end else begin
      DEBUG <= dbg_value;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bootctrl_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_bootctrl_multi
// Brief   : Scoreboard bench for bootctrl_multi: directed boot / gating /
//           watchdog / simultaneity / debug / reset scenarios followed by
//           randomized register traffic against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bootctrl_multi;

  localparam int          N = 2;
  localparam int          R = 16;
  localparam logic [15:0] B = 16'h1000;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [15:0]   WRADDR;
  logic [3:0]    BYTEEN;
  logic          WREN;
  logic [31:0]   WDATA;
  logic [15:0]   RDADDR;
  logic          RDEN;
  logic [31:0]   RDATA;
  logic [63:0]   pcs;
  logic [1:0]    hart_rst;
  logic [63:0]   hart_entry_pc;
  logic [63:0]   hart_dram_base;
  logic [31:0]   DEBUG;

  bootctrl_multi #(.NUM_HARTS(N), .BASE_ADDR(B), .RST_CYCLES(R)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .WRADDR(WRADDR), .BYTEEN(BYTEEN),
    .WREN(WREN), .WDATA(WDATA), .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA),
    .hart_last_pc(pcs), .hart_rst(hart_rst), .hart_entry_pc(hart_entry_pc),
    .hart_dram_base(hart_dram_base), .DEBUG(DEBUG)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States: 0 HOLD, 1 STARTING, 2 RUN, 3 FAULT
  int          m_state [N];
  bit          m_hold  [N];
  logic [31:0] m_dram  [N], m_entry [N], m_odram [N], m_oentry [N];
  logic [31:0] m_wdt   [N], m_prev  [N];
  int unsigned m_start [N];
  logic [31:0] m_limit;
  logic [2:0]  m_sel;
  logic [31:0] m_debug;
  int unsigned cyc;
  logic [31:0] exp_q [$];
  bit          rd_due;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] be);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    logic [15:0] off = a - B;
    int h;
    if (off[1:0] != 2'b00) return 32'd0;
    if (off == 16'h0100) return m_limit;
    if (off == 16'h0104) return {29'b0, m_sel};
    h = int'(off) / 16;
    if (h >= N) return 32'd0;
    case (int'(off) % 16)
      0:  return 32'(m_state[h]) * 8 + ((m_state[h] == 3) ? 32'd4 : 32'd0)
                 + (m_hold[h] ? 32'd2 : 32'd0) + ((m_state[h] == 2) ? 32'd1 : 32'd0);
      4:  return {31'b0, m_hold[h]};
      8:  return m_dram[h];
      default: return m_entry[h];
    endcase
  endfunction

  always @(posedge ACLK or posedge ARESET) begin : model
    logic [15:0] off;
    bit          cw, start, stop, clr, nh;
    int          ns;
    logic [31:0] pc;
    if (ARESET) begin
      for (int h = 0; h < N; h++) begin
        m_state[h] = 0; m_hold[h] = 1; m_dram[h] = 0; m_entry[h] = 0;
        m_odram[h] = 0; m_oentry[h] = 0; m_wdt[h] = 0; m_prev[h] = 0; m_start[h] = 0;
      end
      m_limit = 0; m_sel = 0; m_debug = 0; exp_q.delete(); rd_due = 0; cyc = 0;
    end else begin
      rd_due = RDEN;
      if (RDEN) exp_q.push_back(model_read(RDADDR));
      m_debug = (m_sel < 3'(N)) ? 32'(pcs >> (32 * int'(m_sel))) : 32'd0;
      off = WRADDR - B;
      for (int h = 0; h < N; h++) begin
        pc    = 32'(pcs >> (32 * h));
        cw    = WREN && (off == 16'(16 * h + 4));
        start = cw && BYTEEN[0] && WDATA[1];
        stop  = cw && BYTEEN[0] && WDATA[2];
        clr   = cw && BYTEEN[0] && WDATA[3];
        nh    = (cw && BYTEEN[0]) ? WDATA[0] : m_hold[h];
        ns    = m_state[h];
        case (m_state[h])
          0: if (start && !stop && !nh) begin
               ns = 1; m_start[h] = cyc; m_oentry[h] = m_entry[h]; m_odram[h] = m_dram[h];
             end
          1: if (stop || nh) ns = 0; else if (cyc - m_start[h] == R) ns = 2;
          2: if (stop || nh) ns = 0; else if (m_limit != 0 && m_wdt[h] >= m_limit) ns = 3;
          default: if (clr) ns = 0;
        endcase
        if (ns == 2 && m_state[h] == 1)    m_wdt[h] = 0;
        else if (pc != m_prev[h])          m_wdt[h] = 0;
        else if (m_state[h] == 2 && m_wdt[h] != 32'hFFFF_FFFF) m_wdt[h] = m_wdt[h] + 1;
        m_prev[h]  = pc;
        m_hold[h]  = nh;
        m_state[h] = ns;
        if (WREN && off == 16'(16 * h + 8))  m_dram[h]  = bmerge(m_dram[h], WDATA, BYTEEN);
        if (WREN && off == 16'(16 * h + 12)) m_entry[h] = bmerge(m_entry[h], WDATA, BYTEEN);
      end
      if (WREN && off == 16'h0100) m_limit = bmerge(m_limit, WDATA, BYTEEN);
      if (WREN && off == 16'h0104 && BYTEEN[0]) m_sel = WDATA[2:0];
      cyc++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (rd_due) begin
        if (exp_q.size() == 0) chk("rdata_queue_empty", 64'd1, 64'd0);
        else chk("rdata", {32'b0, RDATA}, {32'b0, exp_q.pop_front()});
      end
      for (int h = 0; h < N; h++) begin
        chk("hart_rst", {63'b0, hart_rst[h]}, {63'b0, (m_state[h] != 2)});
        chk("hart_entry_pc", {32'b0, hart_entry_pc[32*h +: 32]}, {32'b0, m_oentry[h]});
        chk("hart_dram_base", {32'b0, hart_dram_base[32*h +: 32]}, {32'b0, m_odram[h]});
      end
      chk("debug", {32'b0, DEBUG}, {32'b0, m_debug});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    WRADDR = a; BYTEEN = be; WDATA = d; WREN = 1'b1;
    tick();
    WREN = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    RDADDR = a; RDEN = 1'b1;
    tick();
    RDEN = 1'b0;
    d = RDATA;
  endtask

  // Count edges until hart h's reset reaches level lvl (bounded)
  task automatic wait_rst(input int h, input logic lvl, input int limit, output int n);
    n = 0;
    while (hart_rst[h] !== lvl && n < limit) begin
      tick();
      n++;
    end
  endtask

  logic [15:0] addr_tab [16] = '{16'h1000, 16'h1004, 16'h1008, 16'h100C,
                                 16'h1010, 16'h1014, 16'h1018, 16'h101C,
                                 16'h1020, 16'h1024, 16'h1100, 16'h1104,
                                 16'h1108, 16'h0FFC, 16'h1014, 16'h1004};

  initial begin
    logic [31:0] d;
    int n1, n2;
    ARESET = 1'b1; WREN = 0; RDEN = 0; WRADDR = 0; RDADDR = 0; BYTEEN = 0; WDATA = 0;
    pcs = 64'h0000_0200_0000_0100;
    #3;
    chk("rst_hart_rst", {62'b0, hart_rst}, 64'h3);
    chk("rst_rdata", {32'b0, RDATA}, 64'd0);
    chk("rst_debug", {32'b0, DEBUG}, 64'd0);
    chk("rst_entry", hart_entry_pc, 64'd0);
    tick();
    ARESET = 1'b0;
    tick();
    rd(B + 16'h0, d); chk("status0_reset", {32'b0, d}, 64'h02);
    rd(B + 16'h4, d); chk("ctrl0_reset", {32'b0, d}, 64'h01);

    // Boot hart 0
    wr(B + 16'h8, 4'hF, 32'h2000_0000);
    wr(B + 16'hC, 4'hF, 32'h0);
    wr(B + 16'h4, 4'h1, 32'h2);
    wait_rst(0, 1'b0, 40, n1);
    chk("boot_rst_cycles", 64'(n1), 64'(R));
    chk("boot_dram_base", {32'b0, hart_dram_base[31:0]}, 64'h2000_0000);
    rd(B + 16'h0, d); chk("boot_status", {32'b0, d}, 64'h11);

    // Gating: HOLD_RESET=1 with START on hart 1
    wr(B + 16'h14, 4'h1, 32'h3);
    rd(B + 16'h10, d); chk("gate_status1", {32'b0, d}, 64'h02);
    chk("gate_rst1", {63'b0, hart_rst[1]}, 64'd1);
    chk("gate_rst0", {63'b0, hart_rst[0]}, 64'd0);

    // Watchdog: restart hart 0 with constant PC and limit 100
    wr(B + 16'h4, 4'h1, 32'h4);
    wr(B + 16'h100, 4'hF, 32'd100);
    wr(B + 16'h4, 4'h1, 32'h2);
    wait_rst(0, 1'b0, 40, n1);
    // Counter reaches 100 after 100 RUN cycles; FAULT registers on the next edge
    wait_rst(0, 1'b1, 200, n2);
    chk("wdt_run_cycles", 64'(n2), 64'd101);
    rd(B + 16'h0, d); chk("wdt_fault_status", {32'b0, d}, 64'h1C);
    wr(B + 16'h4, 4'h1, 32'h1);
    rd(B + 16'h0, d); chk("fault_hold_set", {32'b0, d}, 64'h1E);
    wr(B + 16'h4, 4'h1, 32'h8);
    rd(B + 16'h0, d); chk("clr_fault_status", {32'b0, d}, 64'h00);

    // STOP+START in RUN, and same-cycle read/write
    wr(B + 16'h100, 4'hF, 32'd0);
    wr(B + 16'h4, 4'h1, 32'h2);
    wait_rst(0, 1'b0, 40, n1);
    wr(B + 16'h4, 4'h1, 32'h6);
    rd(B + 16'h0, d); chk("stop_start_status", {32'b0, d}, 64'h00);
    RDADDR = B + 16'h8; RDEN = 1'b1;
    WRADDR = B + 16'h8; WREN = 1'b1; BYTEEN = 4'hF; WDATA = 32'h1234_5678;
    tick();
    RDEN = 1'b0; WREN = 1'b0;
    chk("rw_same_old", {32'b0, RDATA}, 64'h2000_0000);
    rd(B + 16'h8, d); chk("rw_same_new", {32'b0, d}, 64'h1234_5678);

    // Byte enables, STATUS write, unmapped/out-of-range
    wr(B + 16'h18, 4'b0101, 32'hAABB_CCDD);
    rd(B + 16'h18, d); chk("byteen_merge", {32'b0, d}, 64'h00BB_00DD);
    wr(B + 16'h0, 4'hF, 32'hFFFF_FFFF);
    rd(B + 16'h0, d); chk("status_ro", {32'b0, d}, 64'h00);
    rd(B + 16'h28, d); chk("hart2_unmapped", {32'b0, d}, 64'h0);
    rd(B + 16'h108, d); chk("global_unmapped", {32'b0, d}, 64'h0);

    // DEBUG tap
    pcs[63:32] = 32'h80;
    wr(B + 16'h104, 4'h1, 32'h1);
    tick();
    chk("debug_sel1", {32'b0, DEBUG}, 64'h80);
    wr(B + 16'h104, 4'h1, 32'h7);
    tick();
    chk("debug_sel7", {32'b0, DEBUG}, 64'h0);

    // Asynchronous reset in the middle of STARTING
    wr(B + 16'h1C, 4'hF, 32'h400);
    wr(B + 16'h14, 4'h1, 32'h2);
    tick(); tick(); tick();
    chk("start1_entry", {32'b0, hart_entry_pc[63:32]}, 64'h400);
    chk("start1_rst", {63'b0, hart_rst[1]}, 64'd1);
    #2 ARESET = 1'b1;
    #1;
    chk("arst_hart_rst", {62'b0, hart_rst}, 64'h3);
    chk("arst_entry", hart_entry_pc, 64'd0);
    #2 ARESET = 1'b0;
    tick();
    rd(B + 16'h10, d); chk("arst_status1", {32'b0, d}, 64'h02);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      WREN   = ($urandom_range(0, 2) == 0);
      WRADDR = addr_tab[$urandom_range(0, 15)];
      BYTEEN = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if (WRADDR == 16'h1100)                         WDATA = $urandom_range(0, 40);
      else if (WRADDR == 16'h1004 || WRADDR == 16'h1014) WDATA = $urandom_range(0, 15);
      else                                            WDATA = $urandom;
      RDEN   = ($urandom_range(0, 1) == 0);
      RDADDR = addr_tab[$urandom_range(0, 15)];
      if ($urandom_range(0, 63) == 0) pcs[31:0]  = $urandom;
      if ($urandom_range(0, 63) == 0) pcs[63:32] = $urandom;
      if (i == 1500) begin
        #2 ARESET = 1'b1;
        #2 ARESET = 1'b0;
      end
      tick();
    end
    WREN = 1'b0; RDEN = 1'b0;
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
